// File: rtl/sd_crc_lanes.sv
// rtl/sd_crc_lanes.sv - multi-lane SD CRC7/CRC16 engine with serial emit and receive-check phases
// Optional end-bit handling when SD_CRC_END_BIT_EN is defined.
module sd_crc_lanes #(
    parameter int               CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = 7'h09,
    parameter int               LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   enable_i,
    input  logic [LANES-1:0]       bitval_i,
    input  logic                   emit_i,
    input  logic                   check_i,
    output logic [LANES*CRC_W-1:0] crc_o,
    output logic [LANES-1:0]       out_bit_o,
    output logic                   out_valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LANES-1:0]       crc_err_o
);

    localparam int CNT_W = $clog2(CRC_W + 1);
`ifdef SD_CRC_END_BIT_EN
    localparam int LAST = CRC_W;
`else
    localparam int LAST = CRC_W - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_CHECK} state_t;

    state_t                        state_q, state_d;
    logic [LANES-1:0][CRC_W-1:0]   crc_q, crc_d;
    logic [LANES-1:0]              err_q, err_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          at_last;

    assign at_last = (cnt_q == LAST_CNT);

`ifdef SD_CRC_END_BIT_EN
    // The cycle after the last CRC bit carries the SD end bit.
    logic end_phase;
    assign end_phase = (cnt_q == CNT_W'(CRC_W));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            crc_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = S_CALC;
            crc_d   = '0;
            err_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_CALC: begin
                    // A bit strobed alongside EMIT/CHECK is absorbed before the phase change.
                    if (enable_i) begin
                        for (int i = 0; i < LANES; i++) begin
                            crc_d[i] = {crc_q[i][CRC_W-2:0], 1'b0}
                                     ^ ((bitval_i[i] ^ crc_q[i][CRC_W-1]) ? POLY : '0);
                        end
                    end
                    if (emit_i) begin
                        state_d = S_EMIT;
                        cnt_d   = '0;
                    end else if (check_i) begin
                        state_d = S_CHECK;
                        cnt_d   = '0;
                    end
                end
                S_EMIT: begin
                    for (int i = 0; i < LANES; i++) crc_d[i] = crc_q[i] << 1;
                    if (at_last) state_d = S_IDLE;
                    else         cnt_d   = cnt_q + 1'b1;
                end
                S_CHECK: begin
                    if (enable_i) begin
                        for (int i = 0; i < LANES; i++) begin
`ifdef SD_CRC_END_BIT_EN
                            if (end_phase) begin
                                if (!bitval_i[i]) err_d[i] = 1'b1;
                            end else if (bitval_i[i] != crc_q[i][CRC_W-1]) begin
                                err_d[i] = 1'b1;
                            end
`else
                            if (bitval_i[i] != crc_q[i][CRC_W-1]) err_d[i] = 1'b1;
`endif
                            crc_d[i] = crc_q[i] << 1;
                        end
                        if (at_last) state_d = S_IDLE;
                        else         cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_bit_o = '0;
        if (state_q == S_EMIT) begin
            for (int i = 0; i < LANES; i++) out_bit_o[i] = crc_q[i][CRC_W-1];
`ifdef SD_CRC_END_BIT_EN
            if (end_phase) out_bit_o = '1;
`endif
        end
    end

    assign out_valid_o = (state_q == S_EMIT);
    assign busy_o      = (state_q == S_EMIT) || (state_q == S_CHECK);
    // CLR aborts a phase in flight, so it also suppresses the completion pulse.
    assign done_o      = !clr_i && at_last &&
                         ((state_q == S_EMIT) || ((state_q == S_CHECK) && enable_i));
    assign crc_o       = crc_q;
    assign crc_err_o   = err_q;

endmodule

// File: tb/tb_sd_crc_lanes.sv
// tb/tb_sd_crc_lanes.sv - directed bench for sd_crc_lanes in CMD, 4-lane DAT and 1-lane DAT configurations
module tb_sd_crc_lanes;

`ifdef SD_CRC_END_BIT_EN
    localparam int EB = 1;
`else
    localparam int EB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        clr7, en7, bv7, emit7, chk7;
    logic [6:0]  crc7;
    logic        ob7, ov7, busy7, done7, err7;

    logic        clr4, en4, emit4, chk4;
    logic [3:0]  bv4, ob4, err4;
    logic [63:0] crc4;
    logic        ov4, busy4, done4;

    logic        clr1, en1, bv1, emit1, chk1;
    logic [15:0] crc1;
    logic        ob1, ov1, busy1, done1, err1;

    sd_crc_lanes #(.CRC_W(7), .POLY(7'h09), .LANES(1)) u_cmd (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr7), .enable_i(en7), .bitval_i(bv7),
        .emit_i(emit7), .check_i(chk7), .crc_o(crc7), .out_bit_o(ob7),
        .out_valid_o(ov7), .busy_o(busy7), .done_o(done7), .crc_err_o(err7));

    sd_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_dat4 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr4), .enable_i(en4), .bitval_i(bv4),
        .emit_i(emit4), .check_i(chk4), .crc_o(crc4), .out_bit_o(ob4),
        .out_valid_o(ov4), .busy_o(busy4), .done_o(done4), .crc_err_o(err4));

    sd_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(1)) u_dat1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr1), .enable_i(en1), .bitval_i(bv1),
        .emit_i(emit1), .check_i(chk1), .crc_o(crc1), .out_bit_o(ob1),
        .out_valid_o(ov1), .busy_o(busy1), .done_o(done1), .crc_err_o(err1));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] cmd0;
        logic [6:0]  c7;
        logic [15:0] good, bad;
        logic [7:0]  msg [9];
        logic        early, bit_g, bit_b;
        int          ncyc, vcnt, dcnt;

        cmd0 = 40'h40_0000_0000;
        c7   = 7'h4A;
        good = 16'h7FA1;
        bad  = 16'h7FA0;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

        rst_n = 1'b0;
        {clr7, en7, bv7, emit7, chk7} = '0;
        {clr4, en4, emit4, chk4} = '0; bv4 = '0;
        {clr1, en1, bv1, emit1, chk1} = '0;
        #3;
        check("rst_crc",   {crc7, crc4, crc1}, '0);
        check("rst_valid", {ov7, ov4, ov1, ob7, ob4, ob1}, '0);
        check("rst_busy",  {busy7, busy4, busy1}, '0);
        check("rst_done",  {done7, done4, done1}, '0);
        check("rst_err",   {err7, err4, err1}, '0);
        #9 rst_n = 1'b1;
        cyc();

        // IDLE ignores strobes and EMIT
        en7 = 1'b1; bv7 = 1'b1; emit7 = 1'b1; cyc();
        en7 = 1'b0; bv7 = 1'b0; emit7 = 1'b0; #1;
        check("idle_ignore", {crc7, ov7, busy7}, '0);

        // CMD0 CRC7 then emit
        clr7 = 1'b1; cyc(); clr7 = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            en7 = 1'b1; bv7 = cmd0[i]; cyc();
        end
        en7 = 1'b0; #1;
        check("cmd0_crc7", crc7, 7'h4A);
        emit7 = 1'b1; cyc(); emit7 = 1'b0; #1;
        for (int k = 0; k <= 6 + EB; k++) begin
            check("cmd0_ov", ov7, 1'b1);
            check("cmd0_bit", ob7, (k < 7) ? c7[6-k] : 1'b1);
            check("cmd0_done", done7, (k == 6 + EB) ? 1'b1 : 1'b0);
            cyc();
        end
        check("cmd0_after", {ov7, ob7, busy7, done7, crc7}, '0);

`ifdef SD_CRC_END_BIT_EN
        clr7 = 1'b1; cyc(); clr7 = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            en7 = 1'b1; bv7 = cmd0[i]; cyc();
        end
        en7 = 1'b0; chk7 = 1'b1; cyc(); chk7 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            en7 = 1'b1; bv7 = (k < 7) ? c7[6-k] : 1'b0; cyc();
        end
        en7 = 1'b0; #1;
        check("endbit_err", err7, 1'b1);
`endif

        // 4-lane DAT, 512 bytes of 0xFF, clean CHECK
        clr4 = 1'b1; cyc(); clr4 = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            en4 = 1'b1; bv4 = 4'hF; cyc();
        end
        en4 = 1'b0; #1;
        check("dat4_crc", crc4, {4{16'h7FA1}});
        chk4 = 1'b1; cyc(); chk4 = 1'b0; #1;
        check("dat4_busy", busy4, 1'b1);
        for (int k = 0; k <= 15 + EB; k++) begin
            bit_g = (k < 16) ? good[15-k] : 1'b1;
            en4 = 1'b1; bv4 = {4{bit_g}}; #1;
            check("dat4_done", done4, (k == 15 + EB) ? 1'b1 : 1'b0);
            cyc();
        end
        en4 = 1'b0; #1;
        check("dat4_ok", {err4, busy4, done4, crc4}, '0);

        // Lane 2 corrupted, 3-cycle strobe gaps
        clr4 = 1'b1; cyc(); clr4 = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            en4 = 1'b1; bv4 = 4'hF; cyc();
        end
        en4 = 1'b0; chk4 = 1'b1; cyc(); chk4 = 1'b0;
        early = 1'b0; ncyc = 0; dcnt = 0;
        for (int k = 0; k <= 15 + EB; k++) begin
            if (k > 0) begin
                for (int g = 0; g < 3; g++) begin
                    en4 = 1'b0; #1;
                    if (done4) early = 1'b1;
                    cyc(); ncyc++;
                end
            end
            bit_g = (k < 16) ? good[15-k] : 1'b1;
            bit_b = (k < 16) ? bad[15-k]  : 1'b1;
            en4 = 1'b1; bv4 = {bit_g, bit_b, bit_g, bit_g}; #1;
            if (done4) begin
                if (k == 15 + EB) dcnt++;
                else early = 1'b1;
            end
            cyc(); ncyc++;
        end
        en4 = 1'b0; #1;
        check("gap_early_done", early, 1'b0);
        check("gap_done_seen", dcnt, 1);
        check("gap_cycles", ncyc, 16 + EB + 3 * (15 + EB));
        check("gap_err", err4, 4'b0100);
        check("gap_idle", busy4, 1'b0);

        // 1-lane CRC16 of "123456789"; EMIT and CHECK together
        clr1 = 1'b1; cyc(); clr1 = 1'b0;
        for (int b = 0; b < 9; b++) begin
            for (int i = 7; i >= 0; i--) begin
                en1 = 1'b1; bv1 = msg[b][i]; cyc();
            end
        end
        en1 = 1'b0; #1;
        check("ascii_crc16", crc1, 16'h31C3);
        emit1 = 1'b1; chk1 = 1'b1; cyc(); emit1 = 1'b0; chk1 = 1'b0;
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ov1) vcnt++;
            if (done1) dcnt++;
            cyc();
        end
        check("both_valid_cycles", vcnt, 16 + EB);
        check("both_done_count", dcnt, 1);
        check("both_err", err1, 1'b0);
        check("both_crc", crc1, 16'h0);

        // CLR on 4th EMIT cycle
        clr1 = 1'b1; cyc(); clr1 = 1'b0;
        for (int b = 0; b < 9; b++) begin
            for (int i = 7; i >= 0; i--) begin
                en1 = 1'b1; bv1 = msg[b][i]; cyc();
            end
        end
        en1 = 1'b0; emit1 = 1'b1; cyc(); emit1 = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        clr1 = 1'b1; #1;
        check("abort_ov_now", ov1, 1'b1);
        check("abort_no_done", done1, 1'b0);
        cyc(); clr1 = 1'b0; #1;
        check("abort_after", {ov1, ob1, busy1, done1, crc1}, '0);
        en1 = 1'b1; bv1 = 1'b1; cyc(); en1 = 1'b0; #1;
        check("abort_in_calc", crc1, 16'h1021);

        // Async reset mid-CHECK
        chk1 = 1'b1; cyc(); chk1 = 1'b0; #1;
        check("chk_busy", busy1, 1'b1);
        en1 = 1'b1; bv1 = 1'b1; cyc(); en1 = 1'b0; #1;
        check("chk_err_set", err1, 1'b1);
        #2 rst_n = 1'b0; #1;
        check("async_rst", {crc1, ob1, ov1, busy1, done1, err1}, '0);
        #10 rst_n = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
